// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the RISC-V pipeline hazard controller.
// Holds the opcode constants used by the hazard logic and the
// controller FSM state encoding, so a future forwarding unit can
// reuse the same values.
package hazard_stall_ctrl_pkg;

  // RV32I major opcodes (instruction bits [6:0]).
  localparam logic [6:0] RV_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] RV_OPC_OP     = 7'b0110011;
  localparam logic [6:0] RV_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] RV_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] RV_OPC_JALR   = 7'b1100111;

  // Controller FSM. LU_BUBBLE marks the cycle right after a load-use
  // bubble, when ID/EX still shows the load and must not re-trigger.
  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_LU_BUBBLE = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard compare.
// Flags when the instruction held in ID/EX is a load whose destination
// register (other than x0) is a source of the instruction in ID.
// Ports:
//   if_id_rs1_i, if_id_rs2_i : source registers of the instruction in ID
//   id_ex_opcode_i           : opcode held in ID/EX
//   id_ex_rd_i               : destination register held in ID/EX
//   lu_hit_o                 : load-use hazard present (combinational)
module hazard_cmp
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int         REG_ADDR_WIDTH = 5,
  parameter logic [6:0] OPC_LOAD       = RV_OPC_LOAD
) (
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs2_i,
  input  logic [6:0]                id_ex_opcode_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd_i,
  output logic                      lu_hit_o
);

  logic is_load;
  logic rd_nonzero;
  logic src_match;

  assign is_load    = (id_ex_opcode_i == OPC_LOAD);
  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign rd_nonzero = (id_ex_rd_i != '0);
  assign src_match  = (id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i);
  assign lu_hit_o   = is_load && rd_nonzero && src_match;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage RISC-V core.
// Drives the PC / IF/ID enables, the IF/ID flush, the ID/EX control
// select and a whole-pipeline hold. Handles load-use bubbles (with a
// one-cycle re-detection mask), taken-branch flushes and data-memory
// waits, plus a sticky memory-timeout watchdog and a saturating count
// of load-use bubble cycles.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   IF_ID_rs1, IF_ID_rs2       : sources of the instruction in ID
//   ID_EX_inst_opcode, ID_EX_rd: opcode and destination held in ID/EX
//   EX_pc_sel                  : taken branch/jump resolved in EX
//   dmem_req, dmem_ready       : data-memory request / completion
//   pc_write_en, IF_ID_write_en: front-end register enables
//   IF_ID_flush                : load a NOP into IF/ID
//   ctr_sel                    : ID/EX control select (0 = bubble)
//   pipe_hold                  : freeze ID/EX, EX/MEM, MEM/WB
//   mem_timeout                : sticky watchdog error
//   bubble_cnt                 : saturating load-use bubble count
// All enable outputs are combinational decodes of state and inputs.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int         REG_ADDR_WIDTH = 5,
  parameter logic [6:0] OPC_LOAD       = RV_OPC_LOAD,
  parameter int         MEM_TIMEOUT    = 255,
  parameter int         CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic [6:0]                ID_EX_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_pc_sel,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_write_en,
  output logic                      IF_ID_write_en,
  output logic                      IF_ID_flush,
  output logic                      ctr_sel,
  output logic                      pipe_hold,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      bubble_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e            state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;

  logic lu_hit;
  logic mem_stall;
  logic bubble_inc;

  hazard_cmp #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .OPC_LOAD       (OPC_LOAD)
  ) u_hazard_cmp (
    .if_id_rs1_i    (IF_ID_rs1),
    .if_id_rs2_i    (IF_ID_rs2),
    .id_ex_opcode_i (ID_EX_inst_opcode),
    .id_ex_rd_i     (ID_EX_rd),
    .lu_hit_o       (lu_hit)
  );

  assign mem_stall = dmem_req && !dmem_ready;

  // Next-state and output decode. Priority: memory stall, then branch
  // flush, then load-use (RUN only).
  always_comb begin
    // NOTE: every output gets a default before any branch so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d        = state_q;
    pc_write_en    = 1'b1;
    IF_ID_write_en = 1'b1;
    IF_ID_flush    = 1'b0;
    ctr_sel        = 1'b1;
    pipe_hold      = 1'b0;
    bubble_inc     = 1'b0;

    if (mem_stall) begin
      // Freeze everything; the FSM keeps its state so a pending bubble
      // cycle is replayed after release rather than re-detected.
      pc_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      pipe_hold      = 1'b1;
    end else if (EX_pc_sel) begin
      // Kill the wrong-path instructions in IF/ID and ID while the PC
      // loads the target at the same edge.
      IF_ID_flush = 1'b1;
      ctr_sel     = 1'b0;
      state_d     = ST_RUN;
    end else if ((state_q == ST_RUN) && lu_hit) begin
      pc_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      ctr_sel        = 1'b0;
      bubble_inc     = 1'b1;
      state_d        = ST_LU_BUBBLE;
    end else begin
      // In LU_BUBBLE the ID/EX opcode/rd are stale, so lu_hit is ignored.
      state_d = ST_RUN;
    end
  end

  // Counter and watchdog next-state.
  always_comb begin
    bubble_cnt_d  = bubble_cnt_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;

    if (bubble_inc && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
    end

    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_q == WAIT_MAX) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      bubble_cnt_q  <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed
// by randomized traffic, all compared against a behavioural model that
// tracks whether the dependent instruction has already paid its bubble,
// the length of the current memory-wait streak and the two counters.
module tb_hazard_stall_ctrl;

  localparam int RAW = 5;
  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] ADD  = 7'b0110011;

  logic           clk = 1'b0;
  logic           reset;
  logic [RAW-1:0] rs1, rs2, rd;
  logic [6:0]     opc;
  logic           pc_sel, req, rdy;

  logic           pc_write_en, IF_ID_write_en, IF_ID_flush, ctr_sel, pipe_hold;
  logic           mem_timeout;
  logic [CW-1:0]  bubble_cnt;

  hazard_stall_ctrl #(
    .REG_ADDR_WIDTH (RAW),
    .MEM_TIMEOUT    (TMO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .IF_ID_rs1         (rs1),
    .IF_ID_rs2         (rs2),
    .ID_EX_inst_opcode (opc),
    .ID_EX_rd          (rd),
    .EX_pc_sel         (pc_sel),
    .dmem_req          (req),
    .dmem_ready        (rdy),
    .pc_write_en       (pc_write_en),
    .IF_ID_write_en    (IF_ID_write_en),
    .IF_ID_flush       (IF_ID_flush),
    .ctr_sel           (ctr_sel),
    .pipe_hold         (pipe_hold),
    .mem_timeout       (mem_timeout),
    .bubble_cnt        (bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit m_paid;     // the instruction now in ID already took its bubble
  int m_streak;   // consecutive memory-wait cycles so far
  bit m_to;       // watchdog tripped
  int m_cnt;      // bubbles inserted (saturating)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_paid   = 1'b0;
    m_streak = 0;
    m_to     = 1'b0;
    m_cnt    = 0;
  endtask

  // Apply one cycle of inputs at the falling edge, compare every output
  // against the model, then advance the model to the coming rising edge.
  // Returns before that rising edge, so callers may add extra checks.
  task automatic step(input bit r, input logic [6:0] o, input logic [RAW-1:0] d,
                      input logic [RAW-1:0] s1, input logic [RAW-1:0] s2,
                      input bit ps, input bit rq, input bit ry);
    bit lu, ms;
    bit e_pc, e_ifid, e_flush, e_ctr, e_hold;
    @(negedge clk);
    reset = r; opc = o; rd = d; rs1 = s1; rs2 = s2; pc_sel = ps; req = rq; rdy = ry;
    #1;
    if (r) model_reset();
    lu = (o == LOAD) && (d != 0) && ((d == s1) || (d == s2));
    ms = rq && !ry;
    e_pc = 1; e_ifid = 1; e_flush = 0; e_ctr = 1; e_hold = 0;
    if (ms) begin
      e_pc = 0; e_ifid = 0; e_hold = 1;
    end else if (ps) begin
      e_flush = 1; e_ctr = 0;
    end else if (lu && !m_paid) begin
      e_pc = 0; e_ifid = 0; e_ctr = 0;
    end
    check("pc_write_en",    pc_write_en,    e_pc);
    check("IF_ID_write_en", IF_ID_write_en, e_ifid);
    check("IF_ID_flush",    IF_ID_flush,    e_flush);
    check("ctr_sel",        ctr_sel,        e_ctr);
    check("pipe_hold",      pipe_hold,      e_hold);
    check("mem_timeout",    mem_timeout,    m_to);
    check("bubble_cnt",     bubble_cnt,     m_cnt);
    if (!r) begin
      if (ms) begin
        m_streak++;
        if (m_streak > TMO) m_to = 1'b1;
      end else begin
        m_streak = 0;
        if (!ps && lu && !m_paid) begin
          m_paid = 1'b1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
          m_paid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input bit r);
    step(r, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One load-use hazard plus its bubble cycle.
  task automatic hit_pair();
    step(0, LOAD, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    step(0, LOAD, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
  endtask

  int burst;

  initial begin
    model_reset();
    reset = 1'b1; opc = ADD; rd = '0; rs1 = '0; rs2 = '0;
    pc_sel = 1'b0; req = 1'b0; rdy = 1'b0;

    // Reset state and RUN decode while reset is held.
    idle(1); idle(1);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_mem_timeout", mem_timeout, 0);
    idle(0);

    // Load to x0 then use of x0: no stall.
    step(0, LOAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("x0_no_stall", pc_write_en, 1);
    idle(0);
    check("x0_bubble_cnt", bubble_cnt, 0);

    // Load x5; add x6,x5,x1: exactly one bubble, no re-stall.
    step(0, LOAD, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    check("lu_stall_ctr", ctr_sel, 0);
    step(0, LOAD, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    check("lu_no_restall", pc_write_en, 1);
    check("lu_bubble_cnt", bubble_cnt, 1);
    idle(0);

    // Branch while a load-use hazard is visible: flush wins, state RUN.
    step(0, LOAD, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("br_flush", IF_ID_flush, 1);
    check("br_pc_we", pc_write_en, 1);
    step(0, LOAD, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    check("br_cnt_kept", bubble_cnt, 1);
    check("br_state_run", pc_write_en, 0);
    step(0, LOAD, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);

    // Memory stall during LU_BUBBLE: 3 held cycles, one bubble replay.
    idle(1); idle(0);
    step(0, LOAD, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, LOAD, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0);
      check("lub_hold", pipe_hold, 1);
    end
    step(0, LOAD, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1);
    check("lub_release", pc_write_en, 1);
    idle(0);
    check("lub_bubble_cnt", bubble_cnt, 1);

    // Watchdog: 6 stall cycles, flag rises after the 5th and sticks.
    idle(1); idle(0);
    for (int i = 1; i <= 6; i++) begin
      step(0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("wd_flag", mem_timeout, (i == 6) ? 1 : 0);
    end
    step(0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(0);
    check("wd_sticky", mem_timeout, 1);

    // Reset mid-stall with bubble_cnt=7: counters clear asynchronously.
    idle(1); idle(0);
    for (int i = 0; i < 7; i++) hit_pair();
    for (int i = 0; i < 6; i++) step(0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_cnt", bubble_cnt, 7);
    check("pre_rst_to", mem_timeout, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_cnt", bubble_cnt, 0);
    check("async_rst_to", mem_timeout, 0);
    check("async_rst_hold", pipe_hold, 1);
    model_reset();
    step(1, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("rst_hold_drop", pipe_hold, 0);
    step(0, LOAD, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_state_run", ctr_sel, 0);
    step(0, LOAD, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);

    // Bubble counter saturation.
    idle(1); idle(0);
    for (int i = 0; i < 17; i++) hit_pair();
    idle(0);
    check("cnt_saturate", bubble_cnt, (1 << CW) - 1);

    // Randomized traffic with occasional long memory waits and resets.
    idle(1); idle(0);
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, ps, rq, ry;
      logic [6:0] o;
      logic [RAW-1:0] d, s1, s2;
      r  = ($urandom_range(0, 149) == 0);
      o  = ($urandom_range(0, 1) == 0) ? LOAD : ADD;
      d  = RAW'($urandom_range(0, 3));
      s1 = RAW'($urandom_range(0, 3));
      s2 = RAW'($urandom_range(0, 3));
      ps = ($urandom_range(0, 7) == 0);
      if (burst == 0 && $urandom_range(0, 47) == 0) burst = $urandom_range(3, 8);
      if (burst > 0) begin
        rq = 1'b1; ry = 1'b0; burst--;
      end else begin
        rq = ($urandom_range(0, 2) == 0);
        ry = ($urandom_range(0, 1) == 0);
      end
      step(r, o, d, s1, s2, ps, rq, ry);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
